// File: rtl/uart_pkg.sv
// Shared UART definitions: framing constants, arbiter state encoding and
// default baud divider for a 50 MHz clock at 115200 baud.
package uart_pkg;

  localparam logic UART_START_BIT            = 1'b0;
  localparam logic UART_STOP_BIT             = 1'b1;
  localparam int   UART_FRAME_BITS           = 10;
  localparam int   UART_DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_e;

  // Builds a start/payload/stop frame, start bit in bit 0 so it leaves first.
  function automatic logic [UART_FRAME_BITS-1:0] uart_frame(input logic [UART_FRAME_BITS-3:0] payload);
    return {UART_STOP_BIT, payload, UART_START_BIT};
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame serializer: takes a prebuilt start/data/stop frame on load and
// shifts it out LSB-first, holding each bit for CLKS_PER_BIT cycles.
// The line is the LSB of the shift register, so it is always registered.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W+1:0] frame,
  output logic              saida,
  output logic              done
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_W   = $clog2(FRAME_W);

  logic [FRAME_W-1:0] shift_r;
  logic [BAUD_W-1:0]  baud_r;
  logic [BIT_W-1:0]   bit_r;
  logic               active_r;
  logic               bit_end_s;
  logic               done_s;

  // Last cycle of the current bit, and last cycle of the whole frame.
  always_comb begin
    bit_end_s = 1'b0;
    done_s    = 1'b0;
    if (active_r && (baud_r == BAUD_W'(CLKS_PER_BIT - 1))) begin
      bit_end_s = 1'b1;
      done_s    = (bit_r == BIT_W'(FRAME_W - 1));
    end else begin
      bit_end_s = 1'b0;
      done_s    = 1'b0;
    end
  end

  // Baud/bit counters and shift register; the line idles high when no frame is active.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_r  <= {FRAME_W{1'b1}};
      baud_r   <= {BAUD_W{1'b0}};
      bit_r    <= {BIT_W{1'b0}};
      active_r <= 1'b0;
    end else if (load && !active_r) begin
      shift_r  <= frame;
      baud_r   <= {BAUD_W{1'b0}};
      bit_r    <= {BIT_W{1'b0}};
      active_r <= 1'b1;
    end else if (done_s) begin
      shift_r  <= {FRAME_W{1'b1}};
      baud_r   <= {BAUD_W{1'b0}};
      bit_r    <= {BIT_W{1'b0}};
      active_r <= 1'b0;
    end else if (bit_end_s) begin
      shift_r  <= {1'b1, shift_r[FRAME_W-1:1]};
      baud_r   <= {BAUD_W{1'b0}};
      bit_r    <= bit_r + BIT_W'(1);
    end else if (active_r) begin
      baud_r   <= baud_r + BAUD_W'(1);
    end
  end

  assign saida = shift_r[0];
  assign done  = done_s;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line between N_REQ byte producers.
// In IDLE the first pending requester at or after rr_ptr wins; its byte is
// latched into the serializer and acknowledged with a one-cycle pulse. The
// arbiter stays in SEND until the serializer reports the end of the stop bit.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  data,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     saida
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CW    = IDX_W + 1;

  arb_state_e        state_r;
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [N_REQ-1:0]  ack_r;
  logic [IDX_W-1:0]  grant_r;
  logic              busy_r;

  logic              any_req_s;
  logic              found_s;
  logic [CW-1:0]     cand_s;
  logic [IDX_W-1:0]  winner_s;
  logic [CW-1:0]     ptr_inc_s;
  logic [IDX_W-1:0]  next_ptr_s;
  logic [N_REQ-1:0]  onehot_s;
  logic [DATA_W-1:0] win_data_s;
  logic              load_s;
  logic              ser_done_s;

  // Round-robin search: first pending requester at rr_ptr, rr_ptr+1, ... modulo N_REQ.
  always_comb begin
    found_s  = 1'b0;
    winner_s = {IDX_W{1'b0}};
    cand_s   = {CW{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + CW'(k);
      if (cand_s >= CW'(N_REQ)) begin
        cand_s = cand_s - CW'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[IDX_W-1:0]]) begin
        found_s  = 1'b1;
        winner_s = cand_s[IDX_W-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Pointer moves to the requester just after the winner, wrapping N_REQ-1 -> 0.
  always_comb begin
    ptr_inc_s = {1'b0, winner_s} + CW'(1);
    if (ptr_inc_s == CW'(N_REQ)) begin
      next_ptr_s = {IDX_W{1'b0}};
    end else begin
      next_ptr_s = ptr_inc_s[IDX_W-1:0];
    end
  end

  // Winner's byte and one-hot acknowledge pattern.
  always_comb begin
    win_data_s = {DATA_W{1'b0}};
    onehot_s   = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (winner_s == IDX_W'(i)) begin
        win_data_s  = data[i*DATA_W +: DATA_W];
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
  end

  assign any_req_s = |req;
  assign load_s    = (state_r == ARB_IDLE) && any_req_s;

  // Arbitration FSM with registered ack, grant_id and busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ARB_IDLE;
      rr_ptr_r <= {IDX_W{1'b0}};
      ack_r    <= {N_REQ{1'b0}};
      grant_r  <= {IDX_W{1'b0}};
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (any_req_s) begin
            ack_r    <= onehot_s;
            grant_r  <= winner_s;
            rr_ptr_r <= next_ptr_s;
            busy_r   <= 1'b1;
            state_r  <= ARB_SEND;
          end else begin
            ack_r    <= {N_REQ{1'b0}};
            busy_r   <= 1'b0;
          end
        end
        ARB_SEND: begin
          ack_r <= {N_REQ{1'b0}};
          if (ser_done_s) begin
            busy_r  <= 1'b0;
            state_r <= ARB_IDLE;
          end
        end
        default: begin
          ack_r   <= {N_REQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  uart_tx_serializer #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_serializer (
    .clock (clock),
    .reset (reset),
    .load  (load_s),
    .frame ({UART_STOP_BIT, win_data_s, UART_START_BIT}),
    .saida (saida),
    .done  (ser_done_s)
  );

  assign ack      = ack_r;
  assign grant_id = grant_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with CLKS_PER_BIT=4. Tests push the
// expected (requester, byte) of each frame; a negedge monitor pops one entry
// per frame and checks grant_id, ack, busy and every line cycle.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int C  = 4;
  localparam int FB = 10 * C;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req   = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]  ack;
  logic [1:0]    grant_id;
  logic          busy;
  logic          saida;

  uart_tx_arbiter #(
    .N_REQ        (N),
    .DATA_W       (DW),
    .CLKS_PER_BIT (C)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .saida    (saida)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  bit         mon_en = 1'b0;
  int         exp_id_q[$];
  logic [7:0] exp_byte_q[$];
  int         ack_cyc_q[$];
  int         ack_cnt[N];
  int         total_acks = 0;
  int         cyc = 0;
  bit         dec_active = 1'b0;
  int         dec_n = 0;
  int         dec_id = 0;
  logic [9:0] dec_frame = 10'h3FF;
  logic [3:0] bidx;

  // Frame monitor: sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!mon_en) begin
        dec_active = 1'b0;
        dec_n = 0;
      end else if (!dec_active) begin
        vectors++;
        if (saida === 1'b0) begin
          dec_active = 1'b1;
          dec_n = 1;
          for (int i = 0; i < N; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
          if (ack !== 4'b0000) begin
            total_acks++;
            ack_cyc_q.push_back(cyc);
          end
          if (exp_id_q.size() == 0) begin
            miscompares++;
            $display("FAIL frame_start: unexpected frame grant_id=%0d ack=%b, no frame required", grant_id, ack);
            dec_id = 0;
            dec_frame = 10'h3FF;
          end else begin
            dec_id = exp_id_q.pop_front();
            dec_frame = {1'b1, exp_byte_q.pop_front(), 1'b0};
            if (grant_id !== 2'(dec_id) || ack !== (4'b0001 << dec_id) || busy !== 1'b1) begin
              miscompares++;
              $display("FAIL frame_start: got grant=%0d ack=%b busy=%b, want grant=%0d ack=%b busy=1",
                       grant_id, ack, busy, dec_id, 4'b0001 << dec_id);
            end
          end
        end else if (ack !== 4'b0000 || busy !== 1'b0 || saida !== 1'b1) begin
          miscompares++;
          $display("FAIL idle_line: got saida=%b busy=%b ack=%b, want saida=1 busy=0 ack=0000", saida, busy, ack);
        end
      end else begin
        dec_n++;
        vectors++;
        if (dec_n <= FB) begin
          bidx = 4'((dec_n - 1) / C);
          if (saida !== dec_frame[bidx] || busy !== 1'b1 || ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL frame_bit: cycle %0d of frame got saida=%b busy=%b ack=%b, want saida=%b busy=1 ack=0000",
                     dec_n, saida, busy, ack, dec_frame[bidx]);
          end
        end else begin
          if (saida !== 1'b1 || busy !== 1'b0 || ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL frame_gap: got saida=%b busy=%b ack=%b, want saida=1 busy=0 ack=0000", saida, busy, ack);
          end
          dec_active = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_byte(input int idx, input logic [7:0] b);
    data[idx*DW +: DW] = b;
  endtask

  task automatic push_exp(input int id, input logic [7:0] b);
    exp_id_q.push_back(id);
    exp_byte_q.push_back(b);
  endtask

  task automatic wait_acks(input int target, input int budget, output bit ok);
    int n = 0;
    while (total_acks < target && n < budget) begin
      tick();
      n++;
    end
    ok = (total_acks >= target);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while ((exp_id_q.size() != 0 || dec_active || busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    ok = (exp_id_q.size() == 0 && !dec_active && busy === 1'b0);
  endtask

  task automatic clear_book();
    exp_id_q.delete();
    exp_byte_q.delete();
    ack_cyc_q.delete();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    total_acks = 0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    req = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    clear_book();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    req = 4'b1111;
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (ack !== 4'b0000 || grant_id !== 2'd0 || busy !== 1'b0 || saida !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_state: got ack=%b grant=%0d busy=%b saida=%b, want 0000 0 0 1", ack, grant_id, busy, saida);
      end
      tick();
    end
    req = '0;
    reset = 1'b0;
    tick();
    vectors++;
    if (ack !== 4'b0000 || busy !== 1'b0 || saida !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_idle: got ack=%b busy=%b saida=%b, want 0000 0 1", ack, busy, saida);
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    set_byte(0, 8'h55);
    push_exp(0, 8'h55);
    req = 4'b0001;
    wait_acks(1, 10, ok);
    req = 4'b0000;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL single_ack: got %0d acks, want 1", total_acks); end
    wait_idle(60, ok);
    vectors++;
    if (!ok || ack_cnt[0] != 1 || grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL single_done: got idle=%0b acks0=%0d grant=%0d, want 1 1 0", ok, ack_cnt[0], grant_id);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) set_byte(i, 8'hA0 + 8'(i));
    push_exp(0, 8'hA0); push_exp(1, 8'hA1); push_exp(2, 8'hA2); push_exp(3, 8'hA3); push_exp(0, 8'hA0);
    req = 4'b1111;
    wait_acks(5, 5 * (FB + 1) + 20, ok);
    req = 4'b0000;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rr_acks: got %0d acks, want 5", total_acks); end
    wait_idle(80, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rr_idle: got idle=0, want 1"); end
    for (int i = 0; i + 1 < ack_cyc_q.size(); i++) begin
      vectors++;
      if (ack_cyc_q[i+1] - ack_cyc_q[i] != FB + 1) begin
        miscompares++;
        $display("FAIL rr_spacing: got %0d cycles, want %0d", ack_cyc_q[i+1] - ack_cyc_q[i], FB + 1);
      end
    end
  endtask

  task automatic test_two_req();
    bit ok;
    do_reset();
    set_byte(0, 8'h3C); set_byte(1, 8'h11); set_byte(2, 8'hC3); set_byte(3, 8'h33);
    push_exp(0, 8'h3C); push_exp(2, 8'hC3); push_exp(0, 8'h3C); push_exp(2, 8'hC3);
    req = 4'b0101;
    wait_acks(4, 4 * (FB + 1) + 20, ok);
    req = 4'b0000;
    wait_idle(80, ok);
    vectors++;
    if (!ok || ack_cnt[0] != 2 || ack_cnt[2] != 2 || ack_cnt[1] != 0 || ack_cnt[3] != 0) begin
      miscompares++;
      $display("FAIL two_req_counts: got idle=%0b acks=%0d/%0d/%0d/%0d, want 1 2/0/2/0",
               ok, ack_cnt[0], ack_cnt[1], ack_cnt[2], ack_cnt[3]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    set_byte(2, 8'h96);
    push_exp(2, 8'h96);
    req = 4'b0100;
    wait_acks(1, 10, ok);
    req = 4'b0000;
    repeat (24) tick();
    mon_en = 1'b0;
    reset = 1'b1;
    tick();
    vectors++;
    if (saida !== 1'b1 || busy !== 1'b0 || ack !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset: got saida=%b busy=%b ack=%b, want 1 0 0000", saida, busy, ack);
    end
    reset = 1'b0;
    clear_book();
    set_byte(1, 8'h5A); set_byte(3, 8'hE7);
    push_exp(1, 8'h5A); push_exp(3, 8'hE7);
    mon_en = 1'b1;
    req = 4'b1010;
    wait_acks(1, 10, ok);
    req[1] = 1'b0;
    vectors++;
    if (!ok || grant_id !== 2'd1) begin
      miscompares++;
      $display("FAIL post_reset_grant: got ok=%0b grant=%0d, want 1 1", ok, grant_id);
    end
    wait_acks(2, FB + 20, ok);
    req = 4'b0000;
    wait_idle(60, ok);
    vectors++;
    if (!ok || ack_cnt[3] != 1) begin
      miscompares++;
      $display("FAIL post_reset_second: got idle=%0b acks3=%0d, want 1 1", ok, ack_cnt[3]);
    end
  endtask

  task automatic test_late_req();
    bit ok;
    do_reset();
    set_byte(0, 8'h81); set_byte(2, 8'h24); set_byte(3, 8'h7E);
    push_exp(0, 8'h81); push_exp(3, 8'h7E);
    req = 4'b0001;
    wait_acks(1, 10, ok);
    req[0] = 1'b0;
    repeat (10) tick();
    req[3] = 1'b1;
    req[2] = 1'b1;
    repeat (5) tick();
    req[2] = 1'b0;
    wait_acks(2, FB + 20, ok);
    req = 4'b0000;
    vectors++;
    if (!ok || ack_cyc_q.size() != 2) begin
      miscompares++;
      $display("FAIL late_acks: got %0d acks, want 2", total_acks);
    end else if (ack_cyc_q[1] - ack_cyc_q[0] != FB + 1) begin
      miscompares++;
      $display("FAIL late_spacing: got %0d cycles, want %0d", ack_cyc_q[1] - ack_cyc_q[0], FB + 1);
    end
    wait_idle(60, ok);
    vectors++;
    if (!ok || ack_cnt[2] != 0 || ack_cnt[3] != 1) begin
      miscompares++;
      $display("FAIL late_dropped: got idle=%0b acks2=%0d acks3=%0d, want 1 0 1", ok, ack_cnt[2], ack_cnt[3]);
    end
  endtask

  task automatic test_payload_extremes();
    bit ok;
    int lowc;
    int highc;
    logic [7:0] pat[2];
    int exp_low[2];
    int exp_high[2];
    pat[0] = 8'h00; exp_low[0] = 9 * C - 1; exp_high[0] = C;
    pat[1] = 8'hFF; exp_low[1] = C - 1;     exp_high[1] = 9 * C;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      set_byte(1, pat[p]);
      push_exp(1, pat[p]);
      req = 4'b0010;
      wait_acks(p + 1, FB + 20, ok);
      req = 4'b0000;
      lowc = 0;
      highc = 0;
      while (saida === 1'b0 && lowc < 100) begin lowc++; tick(); end
      while (busy === 1'b1 && saida === 1'b1 && highc < 100) begin highc++; tick(); end
      vectors++;
      if (!ok || lowc != exp_low[p] || highc != exp_high[p]) begin
        miscompares++;
        $display("FAIL payload_%02h: got low=%0d high=%0d, want low=%0d high=%0d",
                 pat[p], lowc, highc, exp_low[p], exp_high[p]);
      end
      wait_idle(20, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL payload_idle: got idle=0, want 1"); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_two_req();
    test_reset_mid_frame();
    test_late_req();
    test_payload_extremes();
    mon_en = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
